// File: rtl/uart_rx.sv
// uart_rx: receive half of the UART pair.
// Turns the asynchronous RX pin into DATA_WIDTH-bit words using
// 1 start bit, DATA_WIDTH data bits (LSB first), 1 stop bit, no parity.
// Every bit is sampled at its centre using an internal bit-period counter.
// Start-bit glitches are rejected, and a low stop bit raises frame_error.

module uart_rx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] received_data,
  output logic                  valid,
  output logic                  frame_error,
  output logic                  busy
);

  // Bit timing derived from the clock and the line rate
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Receiver state
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;

  // Input synchroniser and previous-sample register for edge detection
  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    prev_q, prev_d;
  logic                    rx_s;

  // Stop-bit outcome, turned into the output pulses one cycle later
  logic                    done_ok_q, done_ok_d;
  logic                    done_err_q, done_err_d;

  // Registered outputs
  logic [DATA_WIDTH-1:0]   received_data_q, received_data_d;
  logic                    valid_q, valid_d;
  logic                    frame_error_q, frame_error_d;
  logic                    busy_q, busy_d;

  assign rx_s = sync2_q;

  // Two-flop synchroniser for the async line, plus one extra stage so that
  // IDLE can see a falling edge on rx_s (previous 1, current 0)
  always_comb begin
    sync1_d = line;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // State register: every flop in the block, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      prev_q          <= 1'b1;
      done_ok_q       <= 1'b0;
      done_err_q      <= 1'b0;
      received_data_q <= '0;
      valid_q         <= 1'b0;
      frame_error_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      done_ok_q       <= done_ok_d;
      done_err_q      <= done_err_d;
      received_data_q <= received_data_d;
      valid_q         <= valid_d;
      frame_error_q   <= frame_error_d;
      busy_q          <= busy_d;
    end
  end

  // Next-state logic: walk start/data/stop, sampling each bit at its centre
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    done_ok_d  = 1'b0;
    done_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Only a real high-to-low transition starts a frame, so a line
        // stuck low (break) never retriggers the receiver
        if (prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        // Re-check the line at mid start bit to reject short glitches
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        // One full bit period from mid start bit lands on mid data bit
        if (cnt_q == CNT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        // Leave at mid stop bit so a start bit right behind it is caught
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            done_ok_d = 1'b1;
          end else begin
            done_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: publish the word or the error one cycle after the stop
  // sample; the word is kept until the next good frame overwrites it
  always_comb begin
    valid_d         = done_ok_q;
    frame_error_d   = done_err_q;
    received_data_d = received_data_q;
    if (done_ok_q) begin
      received_data_d = shift_q;
    end
    busy_d = (state_d != IDLE);
  end

  assign received_data = received_data_q;
  assign valid         = valid_q;
  assign frame_error   = frame_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// A monitor logs every valid/frame_error pulse with its clock edge; a
// frame-level model predicts the pulse each transmitted frame should cause.

module tb_uart_rx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUDRATE = 100000;
  localparam int DW       = 8;
  localparam int CPB      = 10;
  localparam int LAT      = 2 + (CPB / 2) + (DW + 1) * CPB + 1;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          line    = 1'b1;
  logic [DW-1:0] received_data;
  logic          valid;
  logic          frame_error;
  logic          busy;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUDRATE  (BAUDRATE),
    .DATA_WIDTH(DW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .line         (line),
    .received_data(received_data),
    .valid        (valid),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    int          edge_no;
  } ev_t;

  ev_t evq[$];
  ev_t expq[$];

  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  logic [7:0] model_last = 8'h00;

  // Free-running clock and posedge counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: record each output pulse and the edge that produced it
  always @(negedge clk) begin
    ev_t e;
    if (valid === 1'b1 || frame_error === 1'b1) begin
      e.is_err  = (frame_error === 1'b1);
      e.data    = received_data;
      e.edge_no = cyc - 1;
      evq.push_back(e);
      checks++;
      if (valid === 1'b1 && frame_error === 1'b1) begin
        fails++;
        $display("[TB] FAIL exclusive: valid=%b frame_error=%b at edge %0d, required not both", valid, frame_error, cyc - 1);
      end
    end
  end

  // Transmit one frame starting right after a negedge and record what the
  // model expects: a word on a high stop bit, an error otherwise
  task automatic applyStimulus(input logic [7:0] d, input bit stop_bit);
    ev_t x;
    x.edge_no = cyc + LAT;
    x.is_err  = !stop_bit;
    if (stop_bit) model_last = d;
    x.data = model_last;
    expq.push_back(x);
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      line = d[i];
      repeat (CPB) @(negedge clk);
    end
    line = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    line    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (received_data !== 8'h00) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h required 00", received_data);
    end
    checks++;
    if (valid !== 1'b0 || frame_error !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_pulses: valid=%b frame_error=%b required 0 0", valid, frame_error);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_busy: got %b required 0", busy);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    evq.delete();
    expq.delete();
  endtask

  task automatic test_single_frame();
    bit busy_seen = 0;
    fork
      applyStimulus(8'hA5, 1'b1);
      repeat (50) begin
        @(negedge clk);
        if (busy === 1'b1) busy_seen = 1;
      end
    join
    repeat (5) @(negedge clk);
    checks++;
    if (!busy_seen) begin
      fails++;
      $display("[TB] FAIL single_busy: busy never high during frame, required high");
    end
    checks++;
    if (evq.size() != expq.size()) begin
      fails++;
      $display("[TB] FAIL single_count: got %0d pulses required %0d", evq.size(), expq.size());
    end
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      checks++;
      if (evq[i].is_err !== expq[i].is_err || evq[i].data !== expq[i].data || evq[i].edge_no != expq[i].edge_no) begin
        fails++;
        $display("[TB] FAIL single_event%0d: got err=%0d data=%h edge=%0d required err=%0d data=%h edge=%0d", i, evq[i].is_err, evq[i].data, evq[i].edge_no, expq[i].is_err, expq[i].data, expq[i].edge_no);
      end
    end
    checks++;
    if (received_data !== 8'hA5 || busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_hold: data=%h busy=%b valid=%b required A5 0 0", received_data, busy, valid);
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_back_to_back();
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (evq.size() != 3) begin
      fails++;
      $display("[TB] FAIL b2b_count: got %0d pulses required 3", evq.size());
    end
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      checks++;
      if (evq[i].is_err !== expq[i].is_err || evq[i].data !== expq[i].data || evq[i].edge_no != expq[i].edge_no) begin
        fails++;
        $display("[TB] FAIL b2b_event%0d: got err=%0d data=%h edge=%0d required err=%0d data=%h edge=%0d", i, evq[i].is_err, evq[i].data, evq[i].edge_no, expq[i].is_err, expq[i].data, expq[i].edge_no);
      end
    end
    if (evq.size() == 3) begin
      checks++;
      if (evq[1].edge_no - evq[0].edge_no != 100 || evq[2].edge_no - evq[1].edge_no != 100) begin
        fails++;
        $display("[TB] FAIL b2b_spacing: got %0d and %0d required 100", evq[1].edge_no - evq[0].edge_no, evq[2].edge_no - evq[1].edge_no);
      end
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_start_glitch();
    bit busy_seen = 0;
    line = 1'b0;
    repeat (3) @(negedge clk);
    line = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy === 1'b1) busy_seen = 1;
    end
    checks++;
    if (!busy_seen || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL glitch_busy: seen=%0d now=%b required seen=1 now=0", busy_seen, busy);
    end
    checks++;
    if (evq.size() != 0) begin
      fails++;
      $display("[TB] FAIL glitch_pulses: got %0d pulses required 0", evq.size());
    end
    evq.delete();
    applyStimulus(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (evq.size() != 1 || evq[0].is_err || evq[0].data !== 8'h5A || evq[0].edge_no != expq[0].edge_no) begin
      fails++;
      $display("[TB] FAIL glitch_next: got %0d pulses data=%h required 1 pulse data=5A", evq.size(), received_data);
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_frame_error();
    applyStimulus(8'h81, 1'b0);
    line = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(8'h42, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (evq.size() != 2) begin
      fails++;
      $display("[TB] FAIL ferr_count: got %0d pulses required 2", evq.size());
    end
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      checks++;
      if (evq[i].is_err !== expq[i].is_err || evq[i].data !== expq[i].data || evq[i].edge_no != expq[i].edge_no) begin
        fails++;
        $display("[TB] FAIL ferr_event%0d: got err=%0d data=%h edge=%0d required err=%0d data=%h edge=%0d", i, evq[i].is_err, evq[i].data, evq[i].edge_no, expq[i].is_err, expq[i].data, expq[i].edge_no);
      end
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_break();
    applyStimulus(8'h99, 1'b0);
    repeat (300) @(negedge clk);
    checks++;
    if (evq.size() != 1 || !evq[0].is_err || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL break_quiet: got %0d pulses busy=%b required 1 error pulse busy=0", evq.size(), busy);
    end
    line = 1'b1;
    repeat (20) @(negedge clk);
    evq.delete();
    expq.delete();
    applyStimulus(8'h11, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (evq.size() != 1 || evq[0].is_err || evq[0].data !== 8'h11 || evq[0].edge_no != expq[0].edge_no) begin
      fails++;
      $display("[TB] FAIL break_next: got %0d pulses data=%h required 1 pulse data=11", evq.size(), received_data);
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'hC3;
    line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      line = d[i];
      repeat (CPB) @(negedge clk);
    end
    line = d[3];
    repeat (CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    line    = 1'b1;
    @(negedge clk);
    checks++;
    if (received_data !== 8'h00 || valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_clear: data=%h valid=%b ferr=%b busy=%b required 00 0 0 0", received_data, valid, frame_error, busy);
    end
    reset_n    = 1'b1;
    model_last = 8'h00;
    repeat (150) @(negedge clk);
    checks++;
    if (evq.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midreset_quiet: got %0d pulses busy=%b required 0 0", evq.size(), busy);
    end
    evq.delete();
    applyStimulus(8'h7E, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (evq.size() != 1 || evq[0].is_err || evq[0].data !== 8'h7E || evq[0].edge_no != expq[0].edge_no) begin
      fails++;
      $display("[TB] FAIL midreset_next: got %0d pulses data=%h required 1 pulse data=7E", evq.size(), received_data);
    end
    evq.delete();
    expq.delete();
  endtask

  task automatic test_random();
    bit last_stop = 1;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d   = 8'($urandom);
      bit         sb  = ($urandom_range(0, 4) != 0);
      int         gap = $urandom_range(0, 30);
      if (!last_stop && gap < 2) gap = 2;
      line = 1'b1;
      repeat (gap) @(negedge clk);
      applyStimulus(d, sb);
      last_stop = sb;
    end
    line = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (evq.size() != expq.size()) begin
      fails++;
      $display("[TB] FAIL random_count: got %0d pulses required %0d", evq.size(), expq.size());
    end
    for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
      checks++;
      if (evq[i].is_err !== expq[i].is_err || evq[i].data !== expq[i].data || evq[i].edge_no != expq[i].edge_no) begin
        fails++;
        $display("[TB] FAIL random_event%0d: got err=%0d data=%h edge=%0d required err=%0d data=%h edge=%0d", i, evq[i].is_err, evq[i].data, evq[i].edge_no, expq[i].is_err, expq[i].data, expq[i].edge_no);
      end
    end
    evq.delete();
    expq.delete();
  endtask

  // Run every scenario in order, then report
  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_glitch();
    test_frame_error();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
